cic_us_feeder: RTL and testbench

Sample scheduler that sits upstream of the CIC interpolator `cic_simple_us`. It accepts samples from a valid/ready stream and buffers them in a small FIFO. It presents them to the CIC's `data_in` with a `data_in_gate` strobe at a programmable period, which sets the CIC input rate. It also handles start-up priming, underruns and shutdown, so the CIC never sees irregular or glitched gates.

---
 rtl/cic_us_feeder.sv | 127 ++++++++++++
 tb/tb_cic_us_feeder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_us_feeder.sv
// Sample scheduler feeding cic_simple_us: buffers a valid/ready stream in a small
// FIFO and releases one sample per programmable gate period.
//
// state | meaning
// IDLE  | disabled; FIFO flushed, outputs held at zero
// PRIME | accepting samples until the FIFO is half full
// RUN   | issuing one gate every P clocks, popping when data is available
module cic_us_feeder #(
  parameter int dw = 16,
  parameter int aw = 2,
  parameter int pw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [pw-1:0] period,
  input  logic          clr_underrun,
  input  logic [dw-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [dw-1:0] data_out,
  output logic          gate,
  output logic [1:0]    state,
  output logic [aw:0]   fifo_level,
  output logic [15:0]   underrun_count
);

  localparam int depth = 1 << aw;
  localparam int half  = 1 << (aw - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        cur, nxt;
  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [pw-1:0] per_q, cnt, per_clamped;
  logic          fifo_full, fifo_empty, strobe, push, pop;

  assign fifo_full   = (fifo_level == (aw+1)'(depth));
  assign fifo_empty  = (fifo_level == '0);
  assign per_clamped = (period < pw'(2)) ? pw'(2) : period;
  // Full FIFO refuses data even when a pop happens in the same cycle.
  assign s_ready     = enable && (cur != IDLE) && !fifo_full;
  assign push        = s_valid && s_ready;
  assign pop         = strobe && !fifo_empty;
  assign state       = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt    = cur;
    strobe = 1'b0;
    case (cur)
      IDLE:    nxt = PRIME;
      PRIME:   if (fifo_level >= (aw+1)'(half)) nxt = RUN;
      RUN:     strobe = (cnt == per_q - pw'(1));
      default: nxt = IDLE;
    endcase
    if (!enable) begin
      nxt    = IDLE;
      strobe = 1'b0;
    end
  end

  // Period is sampled only at RUN entry and at each wrap, never mid-interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      per_q <= pw'(2);
    end else if (nxt != RUN) begin
      cnt <= '0;
    end else if (cur != RUN || cnt == per_q - pw'(1)) begin
      cnt   <= '0;
      per_q <= per_clamped;
    end else begin
      cnt <= cnt + pw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (!enable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (aw+1)'(1);
        2'b01:   fifo_level <= fifo_level - (aw+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate           <= 1'b0;
      data_out       <= '0;
      underrun_count <= '0;
    end else begin
      gate <= strobe;
      if (!enable)  data_out <= '0;
      else if (pop) data_out <= mem[rd_ptr];
      if (clr_underrun)
        underrun_count <= '0;
      else if (strobe && fifo_empty && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cic_us_feeder.sv
// Self-checking bench for cic_us_feeder: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based reference model.
module tb_cic_us_feeder;
  localparam int dw = 16;
  localparam int aw = 2;
  localparam int pw = 8;

  logic          clk = 1'b0;
  logic          rst, enable, clr_underrun, s_valid, s_ready, gate;
  logic [pw-1:0] period;
  logic [dw-1:0] s_data, data_out;
  logic [1:0]    state;
  logic [aw:0]   fifo_level;
  logic [15:0]   underrun_count;

  cic_us_feeder #(.dw(dw), .aw(aw), .pw(pw)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .clr_underrun(clr_underrun), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .data_out(data_out), .gate(gate), .state(state),
    .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO as a queue, interval position as an integer.
  int          m_state, m_pos, m_p, m_und;
  logic        m_gate;
  logic [15:0] m_dout;
  logic [15:0] mq[$];

  logic [15:0] src[$];
  bit          rand_gap = 0;
  int          cyc = 0;
  int          max_level = 0;
  int          gate_times[$];
  logic [15:0] gate_data[$];

  function automatic int clamp(int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_p = 2; m_und = 0; m_gate = 0; m_dout = 0;
    mq.delete();
  endtask

  task automatic drive_src();
    if (src.size() > 0 && !(rand_gap && $urandom_range(0, 2) == 0)) begin
      s_valid = 1'b1;
      s_data  = src[0];
    end else begin
      s_valid = 1'b0;
      s_data  = 16'($urandom);
    end
  endtask

  task automatic step();
    bit ready, push, strobe, was_empty;
    ready     = enable && m_state != 0 && mq.size() < 4;
    push      = s_valid && ready;
    strobe    = enable && m_state == 2 && m_pos == m_p - 1;
    was_empty = (mq.size() == 0);
    @(posedge clk);
    #1;
    cyc++;
    if (!enable) begin
      m_state = 0; m_pos = 0; m_gate = 0; m_dout = 0;
      mq.delete();
    end else begin
      m_gate = strobe;
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (mq.size() >= 2) begin
          m_state = 2; m_pos = 0; m_p = clamp(int'(period));
        end
      end else if (strobe) begin
        if (!was_empty) m_dout = mq.pop_front();
        m_pos = 0;
        m_p = clamp(int'(period));
      end else m_pos++;
      if (push) mq.push_back(s_data);
    end
    if (clr_underrun) m_und = 0;
    else if (strobe && was_empty && m_und < 65535) m_und++;
    if (push && src.size() > 0) void'(src.pop_front());

    chk("state", state, m_state);
    chk("fifo_level", fifo_level, mq.size());
    chk("s_ready", s_ready, enable && m_state != 0 && mq.size() < 4);
    chk("gate", gate, m_gate);
    chk("data_out", data_out, m_dout);
    chk("underrun_count", underrun_count, m_und);
    if (gate === 1'b1) begin
      gate_times.push_back(cyc);
      gate_data.push_back(data_out);
    end
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    drive_src();
  endtask

  task automatic run_gates(int n, int budget);
    int k = 0;
    while (gate_times.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("gate_wait", gate_times.size(), n);
  endtask

  task automatic clear_log();
    gate_times.delete();
    gate_data.delete();
    max_level = 0;
  endtask

  task automatic shut_down();
    enable = 0; src.delete(); drive_src();
    step();
    clr_underrun = 1; step(); clr_underrun = 0;
    clear_log();
  endtask

  initial begin
    rst = 1; enable = 0; clr_underrun = 0; period = 0; s_valid = 0; s_data = 0;
    model_reset();
    #3;
    chk("rst_state", state, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_gate", gate, 0);
    chk("rst_und", underrun_count, 0);
    @(negedge clk); rst = 0;

    // basic cadence
    period = 5; enable = 1; src = '{16'd1, 16'd2, 16'd3, 16'd4}; drive_src();
    run_gates(4, 60);
    for (int i = 0; i < 4 && i < gate_data.size(); i++) chk("cadence_data", gate_data[i], i + 1);
    for (int i = 1; i < 4 && i < gate_times.size(); i++)
      chk("cadence_interval", gate_times[i] - gate_times[i-1], 5);
    chk("cadence_max_level", max_level, 4);
    shut_down();

    // underrun
    period = 4; enable = 1; src = '{16'd10, 16'd20}; drive_src();
    run_gates(5, 60);
    for (int i = 2; i < 5 && i < gate_data.size(); i++) chk("underrun_hold", gate_data[i], 20);
    chk("underrun_count3", underrun_count, 3);
    clr_underrun = 1; step(); clr_underrun = 0;
    chk("underrun_clear", underrun_count, 0);
    shut_down();

    // period clamp then change
    period = 0; enable = 1;
    src = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11}; drive_src();
    run_gates(3, 40);
    period = 7;
    run_gates(5, 40);
    if (gate_times.size() >= 5) begin
      chk("clamp_interval", gate_times[2] - gate_times[1], 2);
      chk("kept_interval", gate_times[3] - gate_times[2], 2);
      chk("new_interval", gate_times[4] - gate_times[3], 7);
    end
    shut_down();

    // full FIFO with pops
    period = 3; enable = 1;
    for (int i = 0; i < 10; i++) src.push_back(16'(100 + i));
    drive_src();
    run_gates(8, 60);
    chk("full_max_level", max_level, 4);
    shut_down();

    // disable mid-run
    period = 4; enable = 1; src = '{16'h11, 16'h22, 16'h33, 16'h44}; drive_src();
    run_gates(1, 40);
    chk("disable_level3", fifo_level, 3);
    chk("disable_dout_before", data_out, 16'h11);
    enable = 0; drive_src();
    step();
    chk("disable_state", state, 0);
    chk("disable_level", fifo_level, 0);
    chk("disable_dout", data_out, 0);
    clear_log();
    for (int i = 0; i < 8; i++) step();
    chk("disable_no_gate", gate_times.size(), 0);
    enable = 1;
    step();
    chk("reenable_prime", state, 1);
    shut_down();

    // async reset while gate is high
    period = 3; enable = 1; src = '{16'h0A, 16'h0B, 16'h0C}; drive_src();
    run_gates(1, 40);
    #2 rst = 1;
    #1;
    chk("arst_gate", gate, 0);
    chk("arst_dout", data_out, 0);
    chk("arst_ready", s_ready, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_state", state, 0);
    model_reset();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 12; i++) step();
    shut_down();

    // randomized traffic
    rand_gap = 1;
    enable = 1;
    for (int i = 0; i < 1500; i++) begin
      if (src.size() < 3) src.push_back(16'($urandom));
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 39) == 0) period = pw'($urandom_range(0, 6));
      clr_underrun = ($urandom_range(0, 49) == 0);
      drive_src();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
